// File: rtl/pattern_video_pkg.sv
// Shared types, constants and helpers for the pattern video generator.
package pattern_video_pkg;

    typedef enum logic [1:0] {
        NOISE = 2'd0,
        BARS  = 2'd1,
        GRID  = 2'd2,
        GRAD  = 2'd3
    } mode_e;

    typedef struct packed {
        logic       pal;
        logic       scandouble;
        mode_e      mode;
        logic [2:0] chan_en;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{pal: 1'b0, scandouble: 1'b0, mode: NOISE, chan_en: 3'b111};

    // Fibonacci taps 32,22,2,1 expressed as bit positions 31,21,1,0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

    // Counter widths never drop below 8 so the gradient can always take 8 low bits.
    function automatic int cnt_width(input int n);
        return ($clog2(n) > 8) ? $clog2(n) : 8;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Pixel divider, raster counters, frame-wrap config latch and registered blank/sync.
module video_timing_counter
    import pattern_video_pkg::*;
#(
    parameter int CE_DIV   = 8,
    parameter int H_ACTIVE = 256,
    parameter int H_TOTAL  = 320,
    parameter int HS_START = 270,
    parameter int HS_LEN   = 24,
    parameter int V_ACTIVE = 240,
    parameter int VS_START = 244,
    parameter int VS_LEN   = 3,
    parameter int V_NTSC   = 262,
    parameter int V_PAL    = 312,
    localparam int HC_W    = cnt_width(H_TOTAL),
    localparam int VC_W    = cnt_width(2 * V_PAL)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pal,
    input  logic            scandouble,
    input  logic [1:0]      mode,
    input  logic [2:0]      chan_en,
    output logic            ce_o,
    output logic            line_end_o,
    output logic [HC_W-1:0] hc_o,
    output logic [VC_W-1:0] sl_o,
    output mode_e           mode_o,
    output logic [2:0]      chan_en_o,
    output logic            ce_pix_o,
    output logic            hblank_o,
    output logic            hsync_o,
    output logic            vblank_o,
    output logic            vsync_o,
    output logic [15:0]     frame_cnt_o
);

    localparam int DIV_W = $clog2(CE_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [HC_W-1:0]  hc_q, hc_d;
    logic [VC_W-1:0]  vc_q, vc_d;
    cfg_t             cfg_q, cfg_d;
    logic             ce_pix_q, ce_pix_d;
    logic             hblank_q, hblank_d, hsync_q, hsync_d;
    logic             vblank_q, vblank_d, vsync_q, vsync_d;
    logic [15:0]      frame_q, frame_d;

    logic [DIV_W-1:0] div_last_s;
    logic [VC_W-1:0]  vt_last_s;
    logic [VC_W-1:0]  sl_s;
    logic             ce_s, line_end_s, frame_end_s;

    // Next-state logic: divider, raster position, config latch and timing outputs.
    always_comb begin
        div_last_s = cfg_q.scandouble ? DIV_W'(CE_DIV / 2 - 1) : DIV_W'(CE_DIV - 1);
        if (cfg_q.pal) begin
            vt_last_s = cfg_q.scandouble ? VC_W'(2 * V_PAL - 1) : VC_W'(V_PAL - 1);
        end else begin
            vt_last_s = cfg_q.scandouble ? VC_W'(2 * V_NTSC - 1) : VC_W'(V_NTSC - 1);
        end
        sl_s        = cfg_q.scandouble ? (vc_q >> 1) : vc_q;
        ce_s        = (div_q == div_last_s);
        line_end_s  = (hc_q == HC_W'(H_TOTAL - 1));
        frame_end_s = line_end_s && (vc_q == vt_last_s);

        div_d    = div_q;
        hc_d     = hc_q;
        vc_d     = vc_q;
        cfg_d    = cfg_q;
        frame_d  = frame_q;
        hblank_d = hblank_q;
        hsync_d  = hsync_q;
        vblank_d = vblank_q;
        vsync_d  = vsync_q;
        ce_pix_d = ce_s;

        if (ce_s) begin
            // Restarting the divider on every strobe makes a period change land cleanly.
            div_d    = '0;
            hblank_d = (hc_q >= HC_W'(H_ACTIVE));
            hsync_d  = (hc_q >= HC_W'(HS_START)) && (hc_q < HC_W'(HS_START + HS_LEN));
            vblank_d = (sl_s >= VC_W'(V_ACTIVE));
            vsync_d  = (sl_s >= VC_W'(VS_START)) && (sl_s < VC_W'(VS_START + VS_LEN));
            if (line_end_s) begin
                hc_d = '0;
                vc_d = frame_end_s ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
            if (frame_end_s) begin
                cfg_d.pal        = pal;
                cfg_d.scandouble = scandouble;
                cfg_d.mode       = mode_e'(mode);
                cfg_d.chan_en    = chan_en;
                frame_d          = frame_q + 16'd1;
            end else begin
                frame_d = frame_q;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            hc_q     <= '0;
            vc_q     <= '0;
            cfg_q    <= CFG_RESET;
            ce_pix_q <= 1'b0;
            hblank_q <= 1'b1;
            hsync_q  <= 1'b0;
            vblank_q <= 1'b1;
            vsync_q  <= 1'b0;
            frame_q  <= 16'd0;
        end else begin
            div_q    <= div_d;
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            cfg_q    <= cfg_d;
            ce_pix_q <= ce_pix_d;
            hblank_q <= hblank_d;
            hsync_q  <= hsync_d;
            vblank_q <= vblank_d;
            vsync_q  <= vsync_d;
            frame_q  <= frame_d;
        end
    end

    assign ce_o        = ce_s;
    assign line_end_o  = line_end_s;
    assign hc_o        = hc_q;
    assign sl_o        = sl_s;
    assign mode_o      = cfg_q.mode;
    assign chan_en_o   = cfg_q.chan_en;
    assign ce_pix_o    = ce_pix_q;
    assign hblank_o    = hblank_q;
    assign hsync_o     = hsync_q;
    assign vblank_o    = vblank_q;
    assign vsync_o     = vsync_q;
    assign frame_cnt_o = frame_q;

endmodule

// File: rtl/pattern_video_gen.sv
// Raster timing plus RGB test patterns (noise, colour bars, grid, gradient).
module pattern_video_gen
    import pattern_video_pkg::*;
#(
    parameter int COLOR_W  = 8,
    parameter int CE_DIV   = 8,
    parameter int H_ACTIVE = 256,
    parameter int H_TOTAL  = 320,
    parameter int HS_START = 270,
    parameter int HS_LEN   = 24,
    parameter int V_ACTIVE = 240,
    parameter int VS_START = 244,
    parameter int VS_LEN   = 3,
    parameter int V_NTSC   = 262,
    parameter int V_PAL    = 312
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pal,
    input  logic               scandouble,
    input  logic [1:0]         mode,
    input  logic [2:0]         chan_en,
    output logic               ce_pix,
    output logic               HBlank,
    output logic               HSync,
    output logic               VBlank,
    output logic               VSync,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic [15:0]        frame_cnt
);

    localparam int HC_W    = cnt_width(H_TOTAL);
    localparam int VC_W    = cnt_width(2 * V_PAL);
    localparam int BAR_PIX = H_ACTIVE / 8;
    localparam int BP_W    = $clog2(BAR_PIX) + 1;

    logic            ce_s, line_end_s;
    logic [HC_W-1:0] hc_s;
    logic [VC_W-1:0] sl_s;
    mode_e           mode_s;
    logic [2:0]      chan_en_s;

    video_timing_counter #(
        .CE_DIV  (CE_DIV),
        .H_ACTIVE(H_ACTIVE),
        .H_TOTAL (H_TOTAL),
        .HS_START(HS_START),
        .HS_LEN  (HS_LEN),
        .V_ACTIVE(V_ACTIVE),
        .VS_START(VS_START),
        .VS_LEN  (VS_LEN),
        .V_NTSC  (V_NTSC),
        .V_PAL   (V_PAL)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .pal        (pal),
        .scandouble (scandouble),
        .mode       (mode),
        .chan_en    (chan_en),
        .ce_o       (ce_s),
        .line_end_o (line_end_s),
        .hc_o       (hc_s),
        .sl_o       (sl_s),
        .mode_o     (mode_s),
        .chan_en_o  (chan_en_s),
        .ce_pix_o   (ce_pix),
        .hblank_o   (HBlank),
        .hsync_o    (HSync),
        .vblank_o   (VBlank),
        .vsync_o    (VSync),
        .frame_cnt_o(frame_cnt)
    );

    // MSB-align an 8-bit value into COLOR_W bits (zero-pad or truncate).
    function automatic logic [COLOR_W-1:0] align8(input logic [7:0] v);
        return COLOR_W'({v, {COLOR_W{1'b0}}} >> 8);
    endfunction

    logic [31:0]        lfsr_q, lfsr_d;
    logic [BP_W-1:0]    bar_pix_q, bar_pix_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    logic [COLOR_W-1:0] pat_r_s, pat_g_s, pat_b_s;
    logic [2:0]         bar_s;
    logic               blank_s, grid_on_s;

    // Pattern selection for the current pixel and next-state of pattern registers.
    always_comb begin
        blank_s   = (hc_s >= HC_W'(H_ACTIVE)) || (sl_s >= VC_W'(V_ACTIVE));
        bar_s     = bar_rgb(bar_idx_q);
        grid_on_s = (hc_s[3:0] == 4'd0) || (sl_s[3:0] == 4'd0) ||
                    (hc_s == HC_W'(H_ACTIVE - 1)) || (sl_s == VC_W'(V_ACTIVE - 1));
        pat_r_s   = '0;
        pat_g_s   = '0;
        pat_b_s   = '0;
        case (mode_s)
            NOISE: begin
                pat_r_s = COLOR_W'(lfsr_q);
                pat_g_s = COLOR_W'(lfsr_q);
                pat_b_s = COLOR_W'(lfsr_q);
            end
            BARS: begin
                pat_r_s = {COLOR_W{bar_s[2]}};
                pat_g_s = {COLOR_W{bar_s[1]}};
                pat_b_s = {COLOR_W{bar_s[0]}};
            end
            GRID: begin
                pat_r_s = {COLOR_W{grid_on_s}};
                pat_g_s = {COLOR_W{grid_on_s}};
                pat_b_s = {COLOR_W{grid_on_s}};
            end
            GRAD: begin
                pat_r_s = align8(hc_s[7:0]);
                pat_g_s = align8(sl_s[7:0]);
                pat_b_s = align8(hc_s[7:0] ^ sl_s[7:0]);
            end
            default: begin
                pat_r_s = '0;
                pat_g_s = '0;
                pat_b_s = '0;
            end
        endcase

        lfsr_d    = lfsr_q;
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        if (ce_s) begin
            lfsr_d = lfsr_next(lfsr_q);
            if (line_end_s) begin
                bar_pix_d = '0;
                bar_idx_d = 3'd0;
            end else if (bar_pix_q == BP_W'(BAR_PIX - 1)) begin
                bar_pix_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_pix_d = bar_pix_q + 1'b1;
            end
            if (blank_s) begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end else begin
                r_d = chan_en_s[2] ? pat_r_s : '0;
                g_d = chan_en_s[1] ? pat_g_s : '0;
                b_d = chan_en_s[0] ? pat_b_s : '0;
            end
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Pattern register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q    <= LFSR_SEED;
            bar_pix_q <= '0;
            bar_idx_q <= 3'd0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign r = r_q;
    assign g = g_q;
    assign b = b_q;

endmodule

// File: tb/tb_pattern_video_gen.sv
// Randomized bench for pattern_video_gen; a reduced raster keeps whole frames short.
module tb_pattern_video_gen;

    localparam int COLOR_W  = 8;
    localparam int CE_DIV   = 4;
    localparam int H_ACTIVE = 32;
    localparam int H_TOTAL  = 40;
    localparam int HS_START = 34;
    localparam int HS_LEN   = 3;
    localparam int V_ACTIVE = 20;
    localparam int VS_START = 22;
    localparam int VS_LEN   = 2;
    localparam int V_NTSC   = 26;
    localparam int V_PAL    = 31;
    localparam int FRAME_BUDGET = 6000;

    localparam logic [2:0] BAR_TAB [0:7] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                             3'b101, 3'b100, 3'b001, 3'b000};

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               pal, scandouble;
    logic [1:0]         mode;
    logic [2:0]         chan_en;
    logic               ce_pix, HBlank, HSync, VBlank, VSync;
    logic [COLOR_W-1:0] r, g, b;
    logic [15:0]        frame_cnt;

    pattern_video_gen #(
        .COLOR_W(COLOR_W), .CE_DIV(CE_DIV), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
        .HS_START(HS_START), .HS_LEN(HS_LEN), .V_ACTIVE(V_ACTIVE), .VS_START(VS_START),
        .VS_LEN(VS_LEN), .V_NTSC(V_NTSC), .V_PAL(V_PAL)
    ) dut (
        .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble), .mode(mode),
        .chan_en(chan_en), .ce_pix(ce_pix), .HBlank(HBlank), .HSync(HSync),
        .VBlank(VBlank), .VSync(VSync), .r(r), .g(g), .b(b), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: pixel index within frame, frame count, frame config, noise state.
    int          m_p, m_frame, m_mode, last_ce, clk_cnt;
    logic        m_pal, m_sd;
    logic [2:0]  m_chan;
    logic [31:0] m_lfsr;
    logic [6:0]  in_smp;

    always @(posedge clk or posedge reset) begin
        if (reset) clk_cnt <= 0;
        else       clk_cnt <= clk_cnt + 1;
    end

    always @(posedge clk) in_smp <= {pal, scandouble, mode, chan_en};

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    function automatic int frame_pixels();
        return H_TOTAL * (m_pal ? V_PAL : V_NTSC) * (m_sd ? 2 : 1);
    endfunction

    function automatic logic [23:0] exp_rgb(input int hc, input int sl, input int md,
                                            input logic [2:0] ch, input logic [31:0] lf);
        logic [7:0] cr, cg, cb;
        logic [2:0] bits;
        cr = 8'h00; cg = 8'h00; cb = 8'h00;
        if (hc < H_ACTIVE && sl < V_ACTIVE) begin
            case (md)
                0: begin cr = lf[7:0]; cg = lf[7:0]; cb = lf[7:0]; end
                1: begin
                    bits = BAR_TAB[hc / (H_ACTIVE / 8)];
                    cr = bits[2] ? 8'hFF : 8'h00;
                    cg = bits[1] ? 8'hFF : 8'h00;
                    cb = bits[0] ? 8'hFF : 8'h00;
                end
                2: if (hc % 16 == 0 || sl % 16 == 0 || hc == H_ACTIVE - 1 || sl == V_ACTIVE - 1) begin
                    cr = 8'hFF; cg = 8'hFF; cb = 8'hFF;
                end
                default: begin cr = 8'(hc); cg = 8'(sl); cb = 8'(hc ^ sl); end
            endcase
        end
        if (!ch[2]) cr = 8'h00;
        if (!ch[1]) cg = 8'h00;
        if (!ch[0]) cb = 8'h00;
        return {cr, cg, cb};
    endfunction

    // Monitor: on every pixel strobe compare all outputs with the model, then advance it.
    initial begin
        int   hc, line, sl;
        logic last;
        logic [1:0] mb;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_p = 0; m_frame = 0; m_pal = 1'b0; m_sd = 1'b0; m_mode = 0;
                m_chan = 3'b111; m_lfsr = 32'hFFFF_FFFF; last_ce = 0;
            end else if (ce_pix) begin
                hc   = m_p % H_TOTAL;
                line = m_p / H_TOTAL;
                sl   = m_sd ? line / 2 : line;
                last = (m_p == frame_pixels() - 1);
                check_eq("ce_interval", clk_cnt - last_ce, m_sd ? CE_DIV / 2 : CE_DIV);
                last_ce = clk_cnt;
                check_eq("hblank", HBlank, hc >= H_ACTIVE);
                check_eq("hsync", HSync, hc >= HS_START && hc < HS_START + HS_LEN);
                check_eq("vblank", VBlank, sl >= V_ACTIVE);
                check_eq("vsync", VSync, sl >= VS_START && sl < VS_START + VS_LEN);
                check_eq("rgb", {r, g, b}, exp_rgb(hc, sl, m_mode, m_chan, m_lfsr));
                check_eq("frame_cnt", frame_cnt, (m_frame + (last ? 1 : 0)) & 16'hFFFF);
                m_lfsr = lfsr_step(m_lfsr);
                m_p++;
                if (last) begin
                    m_p = 0;
                    m_frame++;
                    {m_pal, m_sd, mb, m_chan} = in_smp;
                    m_mode = int'(mb);
                end
            end
        end
    end

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (m_frame < target && n < FRAME_BUDGET * 3) begin
            @(negedge clk); #1;
            n++;
        end
        if (m_frame < target) check_eq("frame_timeout", m_frame, target);
    endtask

    task automatic wait_pixel(input int target);
        int n;
        n = 0;
        while (m_p != target && n < FRAME_BUDGET) begin
            @(negedge clk); #1;
            n++;
        end
        if (m_p != target) check_eq("pixel_timeout", m_p, target);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ce_pix"}, ce_pix, 1'b0);
        check_eq({tag, "_hblank"}, HBlank, 1'b1);
        check_eq({tag, "_vblank"}, VBlank, 1'b1);
        check_eq({tag, "_hsync"}, HSync, 1'b0);
        check_eq({tag, "_vsync"}, VSync, 1'b0);
        check_eq({tag, "_rgb"}, {r, g, b}, 24'h0);
        check_eq({tag, "_frame_cnt"}, frame_cnt, 16'h0);
    endtask

    task automatic randomize_inputs();
        pal        = 1'($urandom_range(0, 1));
        scandouble = 1'($urandom_range(0, 1));
        mode       = 2'($urandom_range(0, 3));
        chan_en    = 3'($urandom_range(0, 7));
    endtask

    initial begin
        int base;
        pal = 1'b0; scandouble = 1'b0; mode = 2'd0; chan_en = 3'b111;
        #2 reset = 1'b1;
        #1 check_reset_values("por");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Defaults for two frames.
        wait_frames(2);
        check_eq("frames_after_2", frame_cnt, 16'd2);

        // PAL and bars requested mid-frame take effect only at the next frame.
        wait_pixel(H_TOTAL * 10 + 5);
        @(negedge clk);
        pal = 1'b1; mode = 2'd1;
        base = m_frame;
        wait_frames(base + 2);

        // Scandoubled grid with a random channel mask.
        wait_pixel(H_TOTAL * 7 + 13);
        @(negedge clk);
        pal = 1'b0; scandouble = 1'b1; mode = 2'd2; chan_en = 3'($urandom_range(1, 7));
        base = m_frame;
        wait_frames(base + 2);

        // Gradient, then fully random mid-frame changes.
        @(negedge clk);
        mode = 2'd3; chan_en = 3'b111;
        base = m_frame;
        wait_frames(base + 2);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(50, 3000)) @(negedge clk);
            randomize_inputs();
        end
        base = m_frame;
        wait_frames(base + 1);

        // Asynchronous reset in the middle of a line.
        randomize_inputs();
        wait_pixel(H_TOTAL * 3 + 25);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_reset_values("midline");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_frames(1);
        check_eq("frames_after_reset", frame_cnt, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
